// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, encodings and control-word types
// for the 5-stage pipeline control unit.
package pipe_ctrl_pkg;

    localparam logic [5:0] R_FORMAT = 6'd0;
    localparam logic [5:0] LW       = 6'd35;
    localparam logic [5:0] SW       = 6'd43;
    localparam logic [5:0] BEQ      = 6'd4;
    localparam logic [5:0] J        = 6'd2;
    localparam logic [5:0] ADDIU    = 6'd9;

    localparam logic [5:0] NOP      = 6'h00;
    localparam logic [5:0] MULTU    = 6'h19;
    localparam logic [5:0] DIVU     = 6'h1B;
    localparam logic [5:0] MFHI     = 6'h10;
    localparam logic [5:0] MFLO     = 6'h12;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [1:0] {
        PC_SEQ = 2'd0,
        PC_BR  = 2'd1,
        PC_JMP = 2'd2
    } pc_sel_e;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_e;

    typedef struct packed {
        logic reg_dst;
        logic alu_src;
        logic mem_to_reg;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic md_start;
    } ctrl_word_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// ID-stage inputs and pipeline control outputs
// of the control unit, bundled as one port.
interface pipe_ctrl_if #(
    parameter int RF_AW   = 5,
    parameter int ALUOP_W = 2
);
    logic               id_valid;
    logic [5:0]         id_opcode;
    logic [5:0]         id_funct;
    logic [RF_AW-1:0]   id_rs;
    logic [RF_AW-1:0]   id_rt;
    logic [RF_AW-1:0]   id_rd;
    logic               branch_eq;

    logic               pc_write;
    logic               ifid_write;
    logic               if_flush;
    logic [1:0]         pc_sel;

    logic               ex_reg_dst;
    logic               ex_alu_src;
    logic               ex_mem_to_reg;
    logic               ex_reg_write;
    logic               ex_mem_read;
    logic               ex_mem_write;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic [RF_AW-1:0]   ex_dest;

    logic               mem_reg_write;
    logic               mem_mem_read;
    logic [RF_AW-1:0]   mem_dest;

    logic               muldiv_start;
    logic               muldiv_busy;
    logic               illegal_op;

    modport master (
        output id_valid, id_opcode, id_funct,
        output id_rs, id_rt, id_rd, branch_eq,
        input  pc_write, ifid_write, if_flush, pc_sel,
        input  ex_reg_dst, ex_alu_src, ex_mem_to_reg,
        input  ex_reg_write, ex_mem_read, ex_mem_write,
        input  ex_alu_op, ex_dest,
        input  mem_reg_write, mem_mem_read, mem_dest,
        input  muldiv_start, muldiv_busy, illegal_op
    );

    modport slave (
        input  id_valid, id_opcode, id_funct,
        input  id_rs, id_rt, id_rd, branch_eq,
        output pc_write, ifid_write, if_flush, pc_sel,
        output ex_reg_dst, ex_alu_src, ex_mem_to_reg,
        output ex_reg_write, ex_mem_read, ex_mem_write,
        output ex_alu_op, ex_dest,
        output mem_reg_write, mem_mem_read, mem_dest,
        output muldiv_start, muldiv_busy, illegal_op
    );

endinterface

// File: rtl/muldiv_tracker.sv
// Tracks the multi-cycle MULTU/DIVU unit: busy for
// exactly MULDIV_LAT cycles after the start pulse.
module muldiv_tracker
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy
);

    md_state_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_BUSY;
                    cnt_d   = 8'(MULDIV_LAT - 1);
                end
            end
            MD_BUSY: begin
                if (start) begin
                    cnt_d = 8'(MULDIV_LAT - 1);
                end else if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID decode, hazard detection and ID/EX + EX/MEM
// control registers for the 5-stage MIPS pipeline.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int RF_AW      = 5,
    parameter int ALUOP_W    = 2,
    parameter int MULDIV_LAT = 32,
    parameter int DELAY_SLOT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave bus
);

    ctrl_word_t         dec;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic [RF_AW-1:0]   dec_dest;
    logic               dec_ill;
    logic               is_beq, is_j, is_md;
    logic               use_rs, use_rt;

    ctrl_word_t         idex_q;
    logic [ALUOP_W-1:0] idex_alu_q;
    logic [RF_AW-1:0]   ex_dest_q;
    logic               mem_rw_q, mem_mr_q;
    logic [RF_AW-1:0]   mem_dest_q;
    logic               ill_q;
    logic               md_busy;

    logic               ld_use, br_hz, md_hz, stall;
    pc_sel_e            pc_sel_d;

    wire [5:0] op = bus.id_opcode;
    wire [5:0] fn = bus.id_funct;

    always_comb begin
        dec        = '0;
        dec_alu_op = '0;
        dec_ill    = 1'b0;
        is_beq     = 1'b0;
        is_j       = 1'b0;
        is_md      = 1'b0;
        use_rs     = 1'b0;
        use_rt     = 1'b0;
        if (bus.id_valid) begin
            unique case (1'b1)
                (op == R_FORMAT): begin
                    if (fn != NOP) begin
                        dec.reg_dst   = 1'b1;
                        dec.reg_write = 1'b1;
                        dec_alu_op    = ALUOP_W'(ALU_FUNCT);
                        use_rs        = 1'b1;
                        use_rt        = 1'b1;
                        if (fn == MULTU || fn == DIVU) begin
                            dec.reg_write = 1'b0;
                            dec.md_start  = 1'b1;
                            is_md         = 1'b1;
                        end
                        if (fn == MFHI || fn == MFLO) begin
                            is_md = 1'b1;
                        end
                    end
                end
                (op == LW): begin
                    dec.alu_src    = 1'b1;
                    dec.mem_to_reg = 1'b1;
                    dec.reg_write  = 1'b1;
                    dec.mem_read   = 1'b1;
                    dec_alu_op     = ALUOP_W'(ALU_ADD);
                    use_rs         = 1'b1;
                end
                (op == SW): begin
                    dec.alu_src   = 1'b1;
                    dec.mem_write = 1'b1;
                    use_rs        = 1'b1;
                    use_rt        = 1'b1;
                end
                (op == BEQ): begin
                    dec_alu_op = ALUOP_W'(ALU_SUB);
                    is_beq     = 1'b1;
                    use_rs     = 1'b1;
                    use_rt     = 1'b1;
                end
                (op == J): begin
                    is_j = 1'b1;
                end
                (op == ADDIU): begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    use_rs        = 1'b1;
                end
                default: dec_ill = 1'b1;
            endcase
        end
    end

    // Undefined or invalid slots carry dest 0 so they stay true bubbles
    always_comb begin
        dec_dest = '0;
        if (bus.id_valid && !dec_ill) begin
            dec_dest = dec.reg_dst ? bus.id_rd : bus.id_rt;
        end
    end

    function automatic logic hit(
        input logic [RF_AW-1:0] d,
        input logic [RF_AW-1:0] s
    );
        return (d != '0) && (d == s);
    endfunction

    assign ld_use = idex_q.mem_read &&
        ((use_rs && hit(ex_dest_q, bus.id_rs)) ||
         (use_rt && hit(ex_dest_q, bus.id_rt)));

    assign br_hz = is_beq && (
        (idex_q.reg_write &&
         (hit(ex_dest_q, bus.id_rs) ||
          hit(ex_dest_q, bus.id_rt))) ||
        (mem_mr_q &&
         (hit(mem_dest_q, bus.id_rs) ||
          hit(mem_dest_q, bus.id_rt))));

    assign md_hz = is_md && (md_busy || idex_q.md_start);
    assign stall = ld_use || br_hz || md_hz;

    always_comb begin
        pc_sel_d = PC_SEQ;
        if (rst_n && !stall) begin
            if (is_j) begin
                pc_sel_d = PC_JMP;
            end else if (is_beq && bus.branch_eq) begin
                pc_sel_d = PC_BR;
            end
        end
    end

    assign bus.pc_write   = rst_n && !stall;
    assign bus.ifid_write = rst_n && !stall;
    assign bus.pc_sel     = pc_sel_d;
    assign bus.if_flush   = (DELAY_SLOT == 0) &&
                            (pc_sel_d != PC_SEQ);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_q     <= '0;
            idex_alu_q <= '0;
            ex_dest_q  <= '0;
            mem_rw_q   <= 1'b0;
            mem_mr_q   <= 1'b0;
            mem_dest_q <= '0;
            ill_q      <= 1'b0;
        end else begin
            mem_rw_q   <= idex_q.reg_write;
            mem_mr_q   <= idex_q.mem_read;
            mem_dest_q <= ex_dest_q;
            ill_q      <= dec_ill;
            if (stall) begin
                idex_q     <= '0;
                idex_alu_q <= '0;
                ex_dest_q  <= '0;
            end else begin
                idex_q     <= dec;
                idex_alu_q <= dec_alu_op;
                ex_dest_q  <= dec_dest;
            end
        end
    end

    muldiv_tracker #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_md (
        .clk   (clk),
        .rst_n (rst_n),
        .start (idex_q.md_start),
        .busy  (md_busy)
    );

    assign bus.ex_reg_dst    = idex_q.reg_dst;
    assign bus.ex_alu_src    = idex_q.alu_src;
    assign bus.ex_mem_to_reg = idex_q.mem_to_reg;
    assign bus.ex_reg_write  = idex_q.reg_write;
    assign bus.ex_mem_read   = idex_q.mem_read;
    assign bus.ex_mem_write  = idex_q.mem_write;
    assign bus.ex_alu_op     = idex_alu_q;
    assign bus.ex_dest       = ex_dest_q;
    assign bus.mem_reg_write = mem_rw_q;
    assign bus.mem_mem_read  = mem_mr_q;
    assign bus.mem_dest      = mem_dest_q;
    assign bus.muldiv_start  = idex_q.md_start;
    assign bus.muldiv_busy   = md_busy;
    assign bus.illegal_op    = ill_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: two instances
// (DELAY_SLOT 0 and 1) driven with the same program.
module tb_pipe_ctrl_unit;
    import pipe_ctrl_pkg::*;

    localparam int F_PCW     = 0;
    localparam int F_IFW     = 1;
    localparam int F_FLUSH   = 2;
    localparam int F_PCSEL   = 3;
    localparam int F_EXW     = 4;
    localparam int F_ALUOP   = 5;
    localparam int F_EXDEST  = 6;
    localparam int F_MMR     = 7;
    localparam int F_MDEST   = 8;
    localparam int F_START   = 9;
    localparam int F_BUSY    = 10;
    localparam int F_ILL     = 11;
    localparam int F_FLUSHDS = 12;
    localparam int F_PCSELDS = 13;
    localparam int F_KNOWN   = 14;

    typedef struct {
        int    cyc;
        string tag;
        int    fld;
        int    val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];

    pipe_ctrl_if #(.RF_AW(5), .ALUOP_W(2)) b0 ();
    pipe_ctrl_if #(.RF_AW(5), .ALUOP_W(2)) b1 ();

    pipe_ctrl_unit #(
        .MULDIV_LAT (4),
        .DELAY_SLOT (0)
    ) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    pipe_ctrl_unit #(
        .MULDIV_LAT (4),
        .DELAY_SLOT (1)
    ) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got,
                         input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, got, exp);
        end
    endtask

    function automatic int get(input int f);
        case (f)
            F_PCW:     return 32'(b0.pc_write);
            F_IFW:     return 32'(b0.ifid_write);
            F_FLUSH:   return 32'(b0.if_flush);
            F_PCSEL:   return 32'(b0.pc_sel);
            F_EXW:     return 32'({b0.ex_reg_dst, b0.ex_alu_src,
                                   b0.ex_mem_to_reg, b0.ex_reg_write,
                                   b0.ex_mem_read, b0.ex_mem_write});
            F_ALUOP:   return 32'(b0.ex_alu_op);
            F_EXDEST:  return 32'(b0.ex_dest);
            F_MMR:     return 32'(b0.mem_mem_read);
            F_MDEST:   return 32'(b0.mem_dest);
            F_START:   return 32'(b0.muldiv_start);
            F_BUSY:    return 32'(b0.muldiv_busy);
            F_ILL:     return 32'(b0.illegal_op);
            F_FLUSHDS: return 32'(b1.if_flush);
            F_PCSELDS: return 32'(b1.pc_sel);
            F_KNOWN:   return 32'(!$isunknown({
                           b0.pc_write, b0.ifid_write, b0.if_flush,
                           b0.pc_sel, b0.ex_reg_dst, b0.ex_alu_src,
                           b0.ex_mem_to_reg, b0.ex_reg_write,
                           b0.ex_mem_read, b0.ex_mem_write,
                           b0.ex_alu_op, b0.ex_dest,
                           b0.mem_reg_write, b0.mem_mem_read,
                           b0.mem_dest, b0.muldiv_start,
                           b0.muldiv_busy, b0.illegal_op}));
            default:   return -1;
        endcase
    endfunction

    task automatic want(input string tag, input int f, input int v);
        exp_t e;
        e.cyc = cyc;
        e.tag = tag;
        e.fld = f;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic step(input logic rst, input logic v,
                        input logic [5:0] op, input logic [5:0] fn,
                        input int rs, input int rt, input int rd,
                        input logic beq);
        @(posedge clk);
        #1;
        rst_n = rst;
        b0.id_valid = v;   b1.id_valid = v;
        b0.id_opcode = op; b1.id_opcode = op;
        b0.id_funct = fn;  b1.id_funct = fn;
        b0.id_rs = 5'(rs); b1.id_rs = 5'(rs);
        b0.id_rt = 5'(rt); b1.id_rt = 5'(rt);
        b0.id_rd = 5'(rd); b1.id_rd = 5'(rd);
        b0.branch_eq = beq; b1.branch_eq = beq;
        cyc++;
    endtask

    task automatic ins(input logic [5:0] op, input logic [5:0] fn,
                       input int rs, input int rt, input int rd,
                       input logic beq);
        step(1'b1, 1'b1, op, fn, rs, rt, rd, beq);
    endtask

    task automatic nop();
        step(1'b1, 1'b0, 6'd0, 6'd0, 0, 0, 0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check(e.tag, get(e.fld), e.val);
        end
    end

    initial begin
        rst_n = 1'b0;
        b0.id_valid = 1'b0; b1.id_valid = 1'b0;
        b0.id_opcode = '0;  b1.id_opcode = '0;
        b0.id_funct = '0;   b1.id_funct = '0;
        b0.id_rs = '0;      b1.id_rs = '0;
        b0.id_rt = '0;      b1.id_rt = '0;
        b0.id_rd = '0;      b1.id_rd = '0;
        b0.branch_eq = 1'b0; b1.branch_eq = 1'b0;

        step(1'b0, 1'b1, J, 6'd0, 0, 0, 0, 1'b0);
        want("rst_pcw", F_PCW, 0);
        want("rst_ifw", F_IFW, 0);
        want("rst_sel", F_PCSEL, 0);
        want("rst_fl", F_FLUSH, 0);
        want("rst_ex", F_EXW, 0);
        want("rst_busy", F_BUSY, 0);
        want("rst_mem", F_MMR, 0);
        want("rst_ill", F_ILL, 0);
        want("rst_known", F_KNOWN, 1);

        // LW $2 ; ADD $3,$2,$4
        ins(LW, 6'd0, 1, 2, 0, 1'b0);
        want("lw_pcw", F_PCW, 1);
        ins(R_FORMAT, 6'h20, 2, 4, 3, 1'b0);
        want("lu_stall", F_PCW, 0);
        want("lu_ifw", F_IFW, 0);
        want("lu_exw", F_EXW, 'h1E);
        want("lu_exd", F_EXDEST, 2);
        ins(R_FORMAT, 6'h20, 2, 4, 3, 1'b0);
        want("lu_bub", F_EXW, 0);
        want("lu_bubd", F_EXDEST, 0);
        want("lu_memr", F_MMR, 1);
        want("lu_memd", F_MDEST, 2);
        want("lu_go", F_PCW, 1);
        nop();
        want("add_exw", F_EXW, 'h24);
        want("add_alu", F_ALUOP, 2);
        want("add_exd", F_EXDEST, 3);

        // LW $5 ; BEQ $5,$0 taken
        ins(LW, 6'd0, 1, 5, 0, 1'b0);
        ins(BEQ, 6'd0, 5, 0, 0, 1'b1);
        want("lb_s1", F_PCW, 0);
        want("lb_s1sel", F_PCSEL, 0);
        want("lb_s1fl", F_FLUSH, 0);
        ins(BEQ, 6'd0, 5, 0, 0, 1'b1);
        want("lb_s2", F_PCW, 0);
        want("lb_s2sel", F_PCSEL, 0);
        ins(BEQ, 6'd0, 5, 0, 0, 1'b1);
        want("lb_go", F_PCW, 1);
        want("lb_sel", F_PCSEL, 1);
        want("lb_fl", F_FLUSH, 1);
        want("lb_fl_ds", F_FLUSHDS, 0);
        want("lb_sel_ds", F_PCSELDS, 1);
        nop();
        want("lb_fl_off", F_FLUSH, 0);
        want("beq_alu", F_ALUOP, 1);

        // ADDIU $6 ; BEQ $6,$6 ; then $0 cases
        ins(ADDIU, 6'd0, 1, 6, 0, 1'b0);
        ins(BEQ, 6'd0, 6, 6, 0, 1'b1);
        want("ab_stall", F_PCW, 0);
        ins(BEQ, 6'd0, 6, 6, 0, 1'b1);
        want("ab_go", F_PCW, 1);
        want("ab_sel", F_PCSEL, 1);
        want("ab_fl", F_FLUSH, 1);
        want("ab_fl_ds", F_FLUSHDS, 0);
        ins(ADDIU, 6'd0, 1, 0, 0, 1'b0);
        ins(BEQ, 6'd0, 0, 0, 0, 1'b0);
        want("z_nostall", F_PCW, 1);
        want("z_exd", F_EXDEST, 0);
        want("z_exw", F_EXW, 'h14);
        want("z_sel", F_PCSEL, 0);

        // MULTU ; MFLO with a 4-cycle unit
        ins(R_FORMAT, MULTU, 1, 2, 0, 1'b0);
        want("mu_go", F_PCW, 1);
        ins(R_FORMAT, MFLO, 0, 0, 7, 1'b0);
        want("md_start", F_START, 1);
        want("md_busy0", F_BUSY, 0);
        want("md_s0", F_PCW, 0);
        ins(R_FORMAT, MFLO, 0, 0, 7, 1'b0);
        want("md_start_off", F_START, 0);
        want("md_busy1", F_BUSY, 1);
        want("md_s1", F_PCW, 0);
        ins(R_FORMAT, MFLO, 0, 0, 7, 1'b0);
        want("md_s2", F_PCW, 0);
        ins(R_FORMAT, MFLO, 0, 0, 7, 1'b0);
        want("md_s3", F_PCW, 0);
        ins(R_FORMAT, MFLO, 0, 0, 7, 1'b0);
        want("md_busy4", F_BUSY, 1);
        want("md_s4", F_PCW, 0);
        ins(R_FORMAT, MFLO, 0, 0, 7, 1'b0);
        want("md_busy_off", F_BUSY, 0);
        want("md_go", F_PCW, 1);
        nop();
        want("mflo_exw", F_EXW, 'h24);
        want("mflo_exd", F_EXDEST, 7);

        // undefined opcode, J, invalid slots
        ins(6'd63, 6'd0, 3, 3, 0, 1'b0);
        want("ill_go", F_PCW, 1);
        nop();
        want("ill_pulse", F_ILL, 1);
        want("ill_exw", F_EXW, 0);
        want("ill_exd", F_EXDEST, 0);
        want("ill_alu", F_ALUOP, 0);
        want("ill_known", F_KNOWN, 1);
        ins(J, 6'd0, 0, 0, 0, 1'b0);
        want("ill_off", F_ILL, 0);
        want("j_sel", F_PCSEL, 2);
        want("j_fl", F_FLUSH, 1);
        want("j_fl_ds", F_FLUSHDS, 0);
        step(1'b1, 1'b0, 6'd63, 6'd0, 0, 0, 0, 1'b1);
        want("inv_sel", F_PCSEL, 0);
        step(1'b1, 1'b0, BEQ, 6'd0, 0, 0, 0, 1'b1);
        want("inv_ill", F_ILL, 0);
        want("inv_bsel", F_PCSEL, 0);
        want("inv_fl", F_FLUSH, 0);

        // reset while busy with LW in ID/EX
        ins(R_FORMAT, MULTU, 1, 2, 0, 1'b0);
        ins(LW, 6'd0, 1, 9, 0, 1'b0);
        want("rb_go", F_PCW, 1);
        want("rb_start", F_START, 1);
        step(1'b0, 1'b1, J, 6'd0, 0, 0, 0, 1'b0);
        want("rb_rst_pcw", F_PCW, 0);
        want("rb_rst_sel", F_PCSEL, 0);
        want("rb_rst_fl", F_FLUSH, 0);
        want("rb_busy_pre", F_BUSY, 1);
        want("rb_ex_lw", F_EXW, 'h1E);
        nop();
        want("rb_ex", F_EXW, 0);
        want("rb_exd", F_EXDEST, 0);
        want("rb_busy", F_BUSY, 0);
        want("rb_mem", F_MMR, 0);
        want("rb_memd", F_MDEST, 0);
        want("rb_sel", F_PCSEL, 0);
        want("rb_pcw", F_PCW, 1);

        @(posedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Parametrised successor to the pipeline control decoder for the 5-stage MIPS core. It decodes opcode/funct in ID and owns the registered ID/EX and EX/MEM control words. It detects load-use and branch-operand hazards, tracks a multi-cycle MULTU/DIVU unit, and drives the PC/IF-ID stall, flush and PC-select signals. Undefined opcodes are turned into bubbles, never X.

Parameters:
RF_AW, 5, register-file address width
ALUOP_W, 2, ALUOp field width (2'b00 add, 2'b01 sub, 2'b10 funct-decoded)
MULDIV_LAT, 32, busy cycles of the mul/div unit after start (legal range 2..255)
DELAY_SLOT, 0, 1 = no IF flush on a taken branch or jump (architectural delay slot)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  synchronous active-low reset
id_valid  in  1  ID holds a real instruction; 0 = treat as NOP
id_opcode  in  6  instruction[31:26]
id_funct  in  6  instruction[5:0]
id_rs  in  RF_AW  source register rs
id_rt  in  RF_AW  source/destination register rt
id_rd  in  RF_AW  destination register rd
branch_eq  in  1  ID comparator result (rs==rt)
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register enable
if_flush  out  1  zero the IF/ID register next edge
pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = jump target
ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  ID/EX control bits
ex_alu_op  out  ALUOP_W  ID/EX ALUOp
ex_dest  out  RF_AW  resolved EX destination (rd or rt)
mem_reg_write, mem_mem_read  out  1 each  EX/MEM control bits
mem_dest  out  RF_AW  EX/MEM destination
muldiv_start  out  1  one-cycle start pulse, aligned with the op in EX
muldiv_busy  out  1  mul/div unit executing
illegal_op  out  1  registered one-cycle pulse for an undefined opcode

Behaviour:
- Decode table:
  - R-type with funct 0: NOP, all bits 0.
  - Other R-type: reg_dst=1, reg_write=1, alu_op=10.
  - MULTU (funct 0x19) and DIVU (funct 0x1B): reg_write=0, and they start mul/div.
  - MFHI (0x10) and MFLO (0x12): R-type write.
  - LW (35): alu_src, mem_to_reg, reg_write and mem_read = 1.
  - SW (43): alu_src=1, mem_write=1.
  - BEQ (4): no EX controls; alu_op=01.
  - J (2): no EX controls.
  - ADDIU (9): alu_src=1, reg_write=1.
  - Any other opcode: all-zero word, and illegal_op pulses the next cycle.
- ex_dest = rd if reg_dst, else rt. A destination of register 0 never matches in hazard checks.
- Load-use stall: ex_mem_read=1 and ex_dest matches id_rs or id_rt, where rt is used only by R-type, SW and BEQ.
- Branch-operand stall: ID holds BEQ and either
  - ex_reg_write with ex_dest matching rs or rt, or
  - mem_mem_read with mem_dest matching rs or rt.
  - A load directly before a BEQ therefore costs 2 stall cycles.
- Mul/div stall: ID holds MFHI, MFLO, MULTU or DIVU while muldiv_busy=1 or muldiv_start=1.
- Any stall: pc_write=0, ifid_write=0, and a bubble (all-zero word, dest 0) is loaded into ID/EX. EX/MEM advances normally.
- No stall: pc_write=1, ifid_write=1. ID/EX loads the decoded word; EX/MEM loads the ID/EX word.
- Redirect, only when not stalled:
  - J: pc_sel=2.
  - BEQ with branch_eq=1: pc_sel=1.
  - if_flush=1 on any redirect when DELAY_SLOT=0; if_flush stays 0 when DELAY_SLOT=1.
  - Stall has priority: a stalled BEQ/J does not redirect until its stall clears.
- pc_write, ifid_write, if_flush and pc_sel are combinational from ID inputs and registered state. All other outputs are registered.
- Mul/div FSM (IDLE, BUSY):
  - muldiv_start=1 for the single cycle the op occupies EX.
  - On that edge: state BUSY, counter = MULDIV_LAT-1.
  - In BUSY the counter decrements each cycle; on reaching 0 it returns to IDLE.
  - muldiv_busy is high for exactly MULDIV_LAT cycles.
  - Stalls never freeze the counter.
- Reset (rst_n=0 at an edge):
  - All ex_* and mem_* outputs = 0; illegal_op=0; muldiv_start=0; FSM IDLE; counter 0.
  - While rst_n=0: pc_write=0, ifid_write=0, if_flush=0, pc_sel=0.
  - Reset during BUSY aborts the operation; muldiv_busy=0 on the next cycle.
- id_valid=0 behaves exactly as NOP: no hazard, no redirect, no illegal_op.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode and funct constants (R_FORMAT, LW, SW, BEQ, J, ADDIU, NOP, MULTU, DIVU, MFHI, MFLO);
  - ALUOp encodings;
  - pc_sel enum (PC_SEQ, PC_BR, PC_JMP);
  - ctrl_word struct;
  - mul/div FSM state enum.
- Sub-module muldiv_tracker holds the IDLE/BUSY FSM and counter. Interface: clk, rst_n, start, busy.

Test Plan:
- LW $2 then ADD $3,$2,$4 -> exactly 1 stall cycle (pc_write=0); bubble in ID/EX; ADD enters EX the following cycle with ex_dest=3.
- LW $5 then BEQ $5,$0, taken -> 2 stall cycles, then pc_sel=1 and if_flush=1 for one cycle. Repeat with DELAY_SLOT=1 -> if_flush stays 0.
- ADDIU $6 then BEQ $6,$6 -> 1 stall cycle. BEQ with a $0 operand after a write to $0 -> no stall.
- MULTU then MFLO (MULDIV_LAT=4) -> muldiv_start 1 cycle, busy 4 cycles; MFLO stalled until busy falls, then issues.
- Opcode 6'd63 -> ID/EX all zero, illegal_op=1 for 1 cycle, no X on any output. J -> pc_sel=2, if_flush=1.
- rst_n=0 for 1 cycle while busy=1 and ID/EX holds LW -> the next cycle all ex_*/mem_* = 0, busy=0, pc_sel=0.
